// File: rtl/div32by16_seq_pkg.sv
// rtl/div32by16_seq_pkg.sv - shared widths, FSM states and constants for the sequential divider
// Purpose: common definitions imported by the divider interface, step and top.
// Ports: none (package).
package div_pkg;

  localparam int DW    = 32;                    // dividend width
  localparam int QW    = 16;                    // divisor / quotient / remainder width
  localparam int CNT_W = 4;                     // iteration counter width (16 steps)

  localparam logic [QW-1:0]    QUOT_SAT = 16'hFFFF;     // saturated quotient on error
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage : div_pkg

// File: rtl/div32by16_seq_if.sv
// rtl/div32by16_seq_if.sv - operand/result handshake bundle for the sequential divider
// Purpose: groups the valid/ready operand channel and the valid/ready result channel.
// Ports (signals): in_valid, in_ready, dividend, divisor, out_valid, out_ready,
//                  quotient, remainder, div_zero, ovf.
// Modports: master = operand producer / result consumer, slave = divider.
interface div32by16_seq_if
  import div_pkg::*;
#(
  parameter int P_DW = DW,
  parameter int P_QW = QW
);

  logic            in_valid;
  logic            in_ready;
  logic [P_DW-1:0] dividend;
  logic [P_QW-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [P_QW-1:0] quotient;
  logic [P_QW-1:0] remainder;
  logic            div_zero;
  logic            ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

endinterface : div32by16_seq_if

// File: rtl/div32by16_seq_restore_step.sv
// rtl/div32by16_seq_restore_step.sv - one combinational radix-2 restoring division step
// Purpose: shifts {R,Q} left by one, trial-subtracts the divisor and restores on borrow.
// Ports: r_i (QW+1) working remainder, q_i (QW) working quotient, divisor_i (QW),
//        r_o (QW+1) next remainder, q_o (QW) next quotient.
module div_restore_step
  import div_pkg::*;
(
  input  logic [QW:0]   r_i,
  input  logic [QW-1:0] q_i,
  input  logic [QW-1:0] divisor_i,
  output logic [QW:0]   r_o,
  output logic [QW-1:0] q_o
);

  // The shifted remainder is kept one bit wider than needed so every bit of r_i
  // feeds the trial; since R < divisor on entry, the top bit of r_sh is always 0
  // and the sign bit here matches the 17-bit trial sign.
  logic [QW+1:0] r_sh;
  logic [QW+1:0] trial;

  always_comb begin
    r_sh  = {r_i, q_i[QW-1]};
    trial = r_sh - {2'b00, divisor_i};
    if (!trial[QW+1]) begin
      r_o = trial[QW:0];
      q_o = {q_i[QW-2:0], 1'b1};
    end else begin
      r_o = r_sh[QW:0];
      q_o = {q_i[QW-2:0], 1'b0};
    end
  end

endmodule : div_restore_step

// File: rtl/div32by16_seq.sv
// rtl/div32by16_seq.sv - sequential 32/16 unsigned restoring divider with valid/ready handshakes
// Purpose: accepts a dividend/divisor pair, produces quotient/remainder one bit per cycle,
//          flags divide-by-zero and quotient overflow early.
// Ports: clk (rising edge), rst_n (async active-low), bus (div32by16_seq_if.slave).
module div32by16_seq
  import div_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  div32by16_seq_if.slave         bus
);

  div_state_t       state_q;
  logic [QW:0]      r_q;
  logic [QW-1:0]    q_q;
  logic [QW-1:0]    dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [QW-1:0]    quot_q;
  logic [QW-1:0]    rem_q;
  logic             dz_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [QW:0]      r_d;
  logic [QW-1:0]    q_d;

  div_restore_step u_step (
    .r_i       (r_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .r_o       (r_d),
    .q_o       (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            r_q        <= {1'b0, bus.dividend[DW-1:QW]};
            q_q        <= bus.dividend[QW-1:0];
            dvs_q      <= bus.divisor;
            in_ready_q <= 1'b0;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          // Classification is registered on the first CHECK cycle; a flagged
          // operation spends one more CHECK cycle so its result appears two
          // cycles after acceptance.
          if (dz_q || ovf_q) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (dvs_q == '0) begin
            dz_q   <= 1'b1;
            quot_q <= QUOT_SAT;
            rem_q  <= q_q;
          end else if (r_q[QW-1:0] >= dvs_q) begin
            // High half already >= divisor: quotient would need more than QW bits.
            ovf_q  <= 1'b1;
            quot_q <= QUOT_SAT;
            rem_q  <= '0;
          end else begin
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            quot_q      <= q_d;
            rem_q       <= r_d[QW-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;

endmodule : div32by16_seq

// File: tb/tb_div32by16_seq.sv
// tb/tb_div32by16_seq.sv - directed self-checking bench for the sequential divider
module tb_div32by16_seq;
  import div_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  div32by16_seq_if bus ();

  div32by16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input string tag, input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_flags_clr"}, {30'd0, bus.div_zero, bus.ovf}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input logic eo, input int elat);
    int lat;
    start(tag, dd, dv);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(ez));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    handoff(tag);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_flags", {30'd0, bus.div_zero, bus.ovf}, 32'd0);
    rst_n = 1'b1;

    run_op("div100_7",   32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17);
    run_op("full_scale", 32'hFFFE_0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17);
    run_op("div_zero",   32'h1234_5678,  16'h0000,   16'hFFFF,   16'h5678,   1'b1, 1'b0, 2);
    run_op("ovf",        32'h0001_0000,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b1, 2);

    // Backpressure: 123456 / 1000 = 123 rem 456, held while new operands are offered.
    start("bp", 32'd123456, 16'd1000);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 32'h0000_0100 + 32'(i);
      bus.divisor  = 16'd3;
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_quotient", 32'(bus.quotient), 32'd123);
      check("bp_remainder", 32'(bus.remainder), 32'd456);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    handoff("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_spurious", 32'(bus.out_valid), 32'd0);
    check("bp_result_kept", 32'(bus.quotient), 32'd123);

    // Reset at iteration 8 of an in-flight division.
    start("rst_mid", 32'd123456, 16'd1000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_quotient", 32'(bus.quotient), 32'd0);
    check("rst_mid_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div32by16_seq
